solver_cpu_cpu_ocimem_arbiter: RTL

Sysclk-domain controller for the debug on-chip memory (OCI RAM) behind the CPU debug slave. It sequences JTAG debug memory commands arriving as single-cycle take_action strobes plus the jdo payload. It arbitrates those commands against CPU-side Avalon debug-slave accesses to one single-port RAM with 1-cycle read latency, and returns JTAG read data on MonDReg.

---
 rtl/solver_cpu_cpu_ocimem_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/solver_cpu_cpu_ocimem_arbiter.sv
// Debug OCI RAM arbiter: sequences JTAG debug memory commands and CPU
// debug-slave accesses onto one single-port RAM with 1-cycle read latency.
module solver_cpu_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_wrdata,
  input  logic [31:0]       ram_rddata
);

  typedef enum logic [2:0] {IDLE, J_ACC, J_CAP, C_WR, C_RD, C_CAP} state_e;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic              overrun_q, overrun_d;
  logic [31:0]       mon_q, mon_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wren_q, ram_wren_d;
  logic [3:0]        ram_be_q, ram_be_d;
  logic [31:0]       ram_wrdata_q, ram_wrdata_d;

  logic busy, strobe_any, post_req, post_ok;
  logic unused_jdo;

  // jdo bits outside the address/data/read-flag fields carry nothing here
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign busy       = pend_q | (state_q == J_ACC) | (state_q == J_CAP);
  assign strobe_any = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
  assign post_req   = take_action_ocimem_b | (take_action_ocimem_a & jdo[35]) |
                      take_no_action_ocimem_a;
  // a command being posted this cycle already outranks the CPU in IDLE
  assign post_ok    = post_req & ~busy;

  // JTAG capture and FSM next-state; capture first, FSM clears/increments after
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_wr_d    = pend_wr_q;
    pend_data_d  = pend_data_q;
    jaddr_d      = jaddr_q;
    overrun_d    = overrun_q;
    mon_d        = mon_q;
    rdata_d      = rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_wren_d   = 1'b0;
    ram_be_d     = ram_be_q;
    ram_wrdata_d = ram_wrdata_q;

    if (strobe_any) begin
      if (busy) begin
        overrun_d = 1'b1;
      end else if (take_action_ocimem_b) begin
        pend_d      = 1'b1;
        pend_wr_d   = 1'b1;
        pend_data_d = jdo[34:3];
      end else if (take_action_ocimem_a) begin
        jaddr_d = jdo[17 +: ADDR_W];
        if (jdo[35]) begin
          pend_d    = 1'b1;
          pend_wr_d = 1'b0;
        end
      end else begin
        pend_d    = 1'b1;
        pend_wr_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d      = J_ACC;
          ram_addr_d   = jaddr_q;
          ram_wren_d   = pend_wr_q;
          ram_be_d     = 4'hF;
          ram_wrdata_d = pend_data_q;
        end else if (!post_ok && avs_write) begin
          state_d      = C_WR;
          ram_addr_d   = avs_address;
          ram_wren_d   = 1'b1;
          ram_be_d     = avs_byteenable;
          ram_wrdata_d = avs_writedata;
        end else if (!post_ok && avs_read) begin
          state_d      = C_RD;
          ram_addr_d   = avs_address;
          ram_be_d     = avs_byteenable;
          ram_wrdata_d = avs_writedata;
        end
      end
      J_ACC: begin
        if (pend_wr_q) begin
          state_d = IDLE;
          jaddr_d = ram_addr_q + ADDR_W'(1);
          pend_d  = 1'b0;
        end else begin
          state_d = J_CAP;
        end
      end
      J_CAP: begin
        mon_d   = ram_rddata;
        jaddr_d = ram_addr_q + ADDR_W'(1);
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      C_WR:  state_d = IDLE;
      C_RD:  state_d = C_CAP;
      C_CAP: begin
        rdata_d = ram_rddata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_data_q  <= '0;
      jaddr_q      <= '0;
      overrun_q    <= 1'b0;
      mon_q        <= '0;
      rdata_q      <= '0;
      ram_addr_q   <= '0;
      ram_wren_q   <= 1'b0;
      ram_be_q     <= '0;
      ram_wrdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_wr_q    <= pend_wr_d;
      pend_data_q  <= pend_data_d;
      jaddr_q      <= jaddr_d;
      overrun_q    <= overrun_d;
      mon_q        <= mon_d;
      rdata_q      <= rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_wren_q   <= ram_wren_d;
      ram_be_q     <= ram_be_d;
      ram_wrdata_q <= ram_wrdata_d;
    end
  end

  assign avs_waitrequest = (avs_read | avs_write) & ~((state_q == C_WR) | (state_q == C_CAP));
  assign avs_readdata    = (state_q == C_CAP) ? ram_rddata : rdata_q;
  assign MonDReg         = mon_q;
  assign jtag_busy       = busy;
  assign jtag_overrun    = overrun_q;
  assign ram_address     = ram_addr_q;
  assign ram_wren        = ram_wren_q;
  assign ram_byteenable  = ram_be_q;
  assign ram_wrdata      = ram_wrdata_q;

endmodule
